if_id_buf: RTL and testbench
============================

// Module: if_id_buf
// PURPOSE
//  IF->ID decoupling buffer: holds {pc, inst} pairs from fetch and presents them to decode.
//  Sits between the PC register / instruction ROM and the ID stage.
//  Provides backpressure to the PC stage (if_ready) and flush on branch/jump redirect.
//  Storage is a small circular FIFO (DEPTH entries); the output is taken from registered state only.
// PARAMETERS
//  ADDR_W  32  width of pc fields (matches `InstAddrBus)
//  INST_W  32  width of instruction fields (matches `InstBus)
//  DEPTH   2   entry count; power of two, >=2
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous reset, active-low (rst==0 resets on posedge clk)
//  if_valid  in   1       fetch presents pc/inst this cycle (driven from PC-stage ce)
//  if_pc     in   ADDR_W  fetch address
//  if_inst   in   INST_W  instruction word at if_pc
//  if_ready  out  1       buffer can accept; PC stage must hold pc when 0
//  flush     in   1       redirect: discard all held and incoming entries
//  id_valid  out  1       id_pc/id_inst hold a real instruction
//  id_pc     out  ADDR_W  head entry pc; 0 when id_valid==0
//  id_inst   out  INST_W  head entry inst; 0 (NOP) when id_valid==0
//  id_ready  in   1       decode consumes head this cycle when id_valid&&id_ready
//  stall_cnt out  32      [IF_ID_PERF_EN only] cycles with if_valid && !if_ready
//  bubble_cnt out 32      [IF_ID_PERF_EN only] cycles with id_ready && !id_valid
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr_ptr=rd_ptr=0, count=0; id_valid=0, id_pc=0, id_inst=0,
//    if_ready=1; perf counters=0. Storage contents need not reset.
//  - push = if_valid && if_ready && !flush; pop = id_valid && id_ready && !flush.
//  - if_ready = (count != DEPTH); a function of registered count only (no comb path from id_ready).
//  - id_valid = (count != 0); id_pc/id_inst = mem[rd_ptr] when valid, else 0.
//  - Latency: an entry pushed at edge N is visible on id_* after edge N (1 cycle); no bypass.
//  - Push and pop in the same cycle: count unchanged; both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  - Full: if_ready=0; if_valid is ignored (PC stage holds). Empty: id_ready is ignored.
//  - flush has priority: at the next edge count=0 and pointers=0; the same-cycle incoming
//    entry is dropped and the same-cycle pop is void; id_valid=0 in the following cycle.
//  - Reset overrides flush. Reset asserted mid-stream discards all entries.
//  - Order: entries leave in strict push order; no duplication, no loss except by flush/reset.
// CONFIGURATION
//  IF_ID_PERF_EN defined: stall_cnt/bubble_cnt ports exist as 32-bit wrapping counters,
//    cleared by reset only (flush does not clear them).
//  IF_ID_PERF_EN undefined: the ports and counters are absent; other behaviour is identical.
// STRUCTURE
//  - defines.vh: `InstAddrBus, `InstBus, `ZeroWord, `NopInst (32'h0), `RstEnable (1'b0 for
//    this block's polarity), `ChipEnable/`ChipDisable.
//  - Sub-module if_id_fifo: storage array, pointers, count, full/empty; parameterised
//    by width/depth. The top level handles flush gating, output zeroing and perf counters.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> id_valid=0, id_pc=0, id_inst=0, if_ready=1.
//  2 Stream: push pc 0x0,0x4,0x8 with id_ready=1 -> id_pc 0x0,0x4,0x8 on consecutive
//    cycles, 1-cycle latency, if_ready stays 1.
//  3 Backpressure: id_ready=0, push 0x0,0x4 -> if_ready=0 after 2nd push; 3rd if_valid
//    ignored; release id_ready -> 0x0,0x4 then 0x8 (re-presented) in order.
//  4 Flush when full with if_valid=1 (pc 0x10) -> next cycle id_valid=0, if_ready=1;
//    0x10 is never seen on id_pc.
//  5 Wrap: 10 push/pop pairs at DEPTH=2 and DEPTH=4 -> pcs 0x0..0x24 in order, none lost.
//  6 IF_ID_PERF_EN: 3 cycles full with if_valid=1 -> stall_cnt=3; 2 idle cycles with
//    id_ready=1 -> bubble_cnt=2; flush leaves both counts unchanged.

Source files
------------

// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg: shared constants for the IF->ID decoupling buffer.
//  RST_ENABLE    level of rst that resets the block (active-low)
//  CHIP_ENABLE   generic enable level used by the fetch side
//  cnt_w()       width of an occupancy counter able to hold 0..depth
package if_id_buf_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Occupancy must represent DEPTH itself, hence one bit beyond the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// if_id_buf_if: fetch/decode handshake bundle around the IF->ID buffer.
//  if_valid/if_pc/if_inst/if_ready  fetch side (ready flows back to PC stage)
//  flush                            redirect, discards everything held
//  id_valid/id_pc/id_inst/id_ready  decode side
//  master: the surrounding pipeline; slave: the buffer.
interface if_id_buf_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              flush;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready;

  modport master (
    output if_valid, if_pc, if_inst, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst
  );

  modport slave (
    input  if_valid, if_pc, if_inst, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_id_buf_fifo.sv
// if_id_fifo: circular FIFO storage for the IF->ID buffer.
//  clk, rst   clock, synchronous active-low reset
//  clr        synchronous clear of pointers/occupancy (flush)
//  push/wdata write an entry (ignored when full)
//  pop        retire the head (ignored when empty)
//  rdata      head entry, straight from the storage array
//  full/empty occupancy flags, registered state only
module if_id_fifo
  import if_id_buf_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf: IF->ID decoupling buffer holding {pc, inst} pairs.
//  clk        rising-edge clock
//  rst        synchronous reset, active-low
//  bus        if_id_buf_if.slave: fetch handshake (if_*), flush, decode handshake (id_*)
//  stall_cnt  cycles with if_valid && !if_ready    (IF_ID_PERF_EN only)
//  bubble_cnt cycles with id_ready && !id_valid    (IF_ID_PERF_EN only)
// Optional feature: define IF_ID_PERF_EN to add the two 32-bit wrapping perf
// counters; they are cleared by reset only, never by flush.
// Outputs come from registered state only: if_ready depends on occupancy, not
// on id_ready, so there is no combinational path across the buffer.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  if_id_buf_if.slave  bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int W = ADDR_W + INST_W;

  logic         push, pop;
  logic         full, empty;
  logic [W-1:0] rdata;

  // flush voids both the incoming entry and the same-cycle pop.
  assign push = bus.if_valid && !full && !bus.flush;
  assign pop  = !empty && bus.id_ready && !bus.flush;

  if_id_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .push  (push),
    .wdata ({bus.if_pc, bus.if_inst}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign bus.if_ready = !full;
  assign bus.id_valid = !empty;
  // Empty buffer presents pc 0 and a NOP so decode never sees stale storage.
  assign bus.id_pc    = empty ? '0 : rdata[W-1 -: ADDR_W];
  assign bus.id_inst  = empty ? '0 : rdata[INST_W-1:0];

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.if_valid && full)  stall_cnt  <= stall_cnt + 32'd1;
      if (bus.id_ready && empty) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf: scoreboard bench for if_id_buf (DEPTH=2).
// The driver acts as the PC stage (holds pc until accepted) and, at every
// rising edge, updates a queue model of what the buffer must hold. A separate
// monitor compares DUT outputs against the model head on every falling edge.
module tb_if_id_buf;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_id_buf_if #(.ADDR_W(32), .INST_W(32)) bus ();

`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  if_id_buf #(
    .ADDR_W (32),
    .INST_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  ent_t        exp_q[$];
  int unsigned stall_m  = 0;
  int unsigned bubble_m = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;
  bit          mon_en   = 0;
  bit          watch10  = 0;
  bit          seen10   = 0;
  bit          acc      = 0;
  logic [31:0] pc_cur   = '0;
  logic [31:0] inst_cur = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: the buffer is an ordered list of at most DEPTH entries.
  task automatic model_step();
    int   n;
    ent_t e;
    n   = exp_q.size();
    acc = 0;
    if (rst == 1'b0) begin
      exp_q.delete();
      stall_m  = 0;
      bubble_m = 0;
    end else begin
      if (bus.if_valid && n == DEPTH) stall_m++;
      if (bus.id_ready && n == 0)     bubble_m++;
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (bus.id_ready && n != 0) void'(exp_q.pop_front());
        if (bus.if_valid && n != DEPTH) begin
          e.pc   = bus.if_pc;
          e.inst = bus.if_inst;
          exp_q.push_back(e);
          acc = 1;
        end
      end
    end
  endtask

  // One clock of stimulus: apply, take the edge, update the model, advance pc.
  task automatic step(input logic v, input logic fl, input logic rdy);
    bus.if_valid = v;
    bus.flush    = fl;
    bus.id_ready = rdy;
    bus.if_pc    = pc_cur;
    bus.if_inst  = inst_cur;
    @(posedge clk);
    model_step();
    mon_en = 1;
    if (acc) begin
      pc_cur   = pc_cur + 32'd4;
      inst_cur = $urandom;
    end
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    pc_cur   = pc;
    inst_cur = $urandom;
  endtask

  // Monitor: compares registered outputs mid-cycle against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("id_valid", {31'd0, bus.id_valid}, {31'd0, exp_q.size() != 0});
      chk("if_ready", {31'd0, bus.if_ready}, {31'd0, exp_q.size() != DEPTH});
      chk("id_pc",    bus.id_pc,   exp_q.size() != 0 ? exp_q[0].pc   : 32'd0);
      chk("id_inst",  bus.id_inst, exp_q.size() != 0 ? exp_q[0].inst : 32'd0);
`ifdef IF_ID_PERF_EN
      chk("stall_cnt",  stall_cnt,  stall_m);
      chk("bubble_cnt", bubble_cnt, bubble_m);
`endif
      if (watch10 && bus.id_valid && bus.id_pc == 32'h10) seen10 = 1;
    end
  end

  initial begin
    int cnt;
`ifdef IF_ID_PERF_EN
    int unsigned s0, b0;
`endif
    bus.if_valid = 0;
    bus.flush    = 0;
    bus.id_ready = 0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;

    // 1: reset held two cycles
    rst = 1'b0;
    step(1, 0, 1);
    step(1, 0, 1);
    chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd1);
    rst = 1'b1;

    // 2: stream 0x0,0x4,0x8 with decode always ready
    set_pc(32'h0);
    repeat (3) step(1, 0, 1);
    repeat (2) step(0, 0, 1);

    // 3: backpressure, third pc held by the PC stage until accepted
    set_pc(32'h0);
    repeat (4) step(1, 0, 0);
    chk("bp_if_ready", {31'd0, bus.if_ready}, 32'd0);
    chk("bp_head_pc",  bus.id_pc, 32'h0);
    cnt = 0;
    while (pc_cur != 32'hC && cnt < 20) begin
      step(1, 0, 1);
      cnt++;
    end
    chk("bp_accept_8", pc_cur, 32'hC);
    repeat (3) step(0, 0, 1);

    // 4: flush while full with a live incoming entry
    set_pc(32'h0);
    repeat (2) step(1, 0, 0);
    set_pc(32'h10);
    watch10 = 1;
    step(1, 1, 0);
    chk("flush_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("flush_if_ready", {31'd0, bus.if_ready}, 32'd1);
    set_pc(32'h80);
    repeat (3) step(0, 0, 1);
    repeat (2) step(1, 0, 1);
    repeat (2) step(0, 0, 1);
    watch10 = 0;
    chk("flush_drop_10", {31'd0, seen10}, 32'd0);

    // 5: ten push/pop pairs wrap the pointers several times
    set_pc(32'h0);
    cnt = 0;
    while (pc_cur != 32'h28 && cnt < 40) begin
      step(1, 0, 1);
      cnt++;
    end
    chk("wrap_count", pc_cur, 32'h28);
    repeat (3) step(0, 0, 1);

`ifdef IF_ID_PERF_EN
    // 6: perf counters
    set_pc(32'h200);
    repeat (2) step(1, 0, 0);
    s0 = stall_m;
    repeat (3) step(1, 0, 0);
    chk("perf_stall3", stall_cnt, s0 + 3);
    repeat (2) step(0, 0, 1);
    b0 = bubble_m;
    repeat (2) step(0, 0, 1);
    chk("perf_bubble2", bubble_cnt, b0 + 2);
    step(0, 1, 0);
    chk("perf_flush_stall",  stall_cnt,  s0 + 3);
    chk("perf_flush_bubble", bubble_cnt, b0 + 2);
`endif

    // Reset in the middle of a stream discards held entries
    set_pc(32'h300);
    repeat (2) step(1, 0, 0);
    rst = 1'b0;
    step(1, 0, 1);
    rst = 1'b1;
    chk("midrst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("midrst_id_pc",    bus.id_pc, 32'd0);

    // Random traffic with occasional flush and reset
    set_pc(32'h1000);
    for (int i = 0; i < 500; i++) begin
      logic v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step(v, f, r);
      if (f) set_pc(pc_cur + 32'h100);
    end
    rst = 1'b1;
    repeat (4) step(0, 0, 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
